// File: rtl/lcd_spi_rx.sv
// Purpose  : panel-side receiver for the PMOD LCD 4-wire SPI link; decodes DC-tagged bytes and checks LCD reset pulse widths.
// Latency  : pin edge to use is SYNC_STAGES+1 cycles; a byte appears on o_byte_* the cycle after its 8th synced SCL rise.
// Backpress: single output register with valid/ready; a byte completing while the register is full is dropped and flagged on o_overrun.
//
// Ports:
//   i_clk, i_rst_n                 system clock, async active-low reset
//   i_lcd_scl/mosi/dc/cs/rst       raw LCD pins (SCL rise samples MOSI, MSB first; CS and RST active low)
//   o_byte_data/o_byte_dc          received byte and its DC tag
//   o_byte_valid/i_byte_ready      output handshake
//   o_overrun, o_abort             1-cycle pulses: byte dropped / CS released mid-byte
//   o_hwrst_done, o_rst_glitch     1-cycle pulses: LCD_RST released after a long enough / too short low time
//   o_last_cmd, o_disp_on, o_sleep_out  command decode status
// Build option: define LCD_SPI_RX_CMD_DECODE_EN to build the command decoder; otherwise its outputs are tied to 0.

module lcd_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_MIN_CYC = 120,
    parameter int RST_CNT_W   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lcd_scl,
    input  logic       i_lcd_mosi,
    input  logic       i_lcd_dc,
    input  logic       i_lcd_cs,
    input  logic       i_lcd_rst,
    output logic [7:0] o_byte_data,
    output logic       o_byte_dc,
    output logic       o_byte_valid,
    input  logic       i_byte_ready,
    output logic       o_overrun,
    output logic       o_abort,
    output logic       o_hwrst_done,
    output logic       o_rst_glitch,
    output logic [7:0] o_last_cmd,
    output logic       o_disp_on,
    output logic       o_sleep_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_LCDRST = 2'd2
    } state_t;

    // Pin vector order: {rst, cs, dc, mosi, scl}
    logic [4:0] w_pins;
    logic [4:0] r_sync [SYNC_STAGES];
    logic       r_scl_prev;

    logic w_scl_s, w_mosi_s, w_dc_s, w_cs_s, w_rst_s, w_scl_rise;

    state_t r_state, w_state_nxt;

    logic [7:0]           r_shift;
    logic [2:0]           r_bit_cnt;
    logic [RST_CNT_W-1:0] r_rst_cnt;
    logic [7:0]           r_data;
    logic                 r_dc;
    logic                 r_valid;
    logic                 r_overrun, r_abort, r_hwrst_done, r_rst_glitch;

    logic       w_shift_en, w_clr_bits, w_abort_evt, w_rst_run, w_rst_rel;
    logic       w_byte_done, w_load, w_ovr_evt, w_hw_ok, w_glitch;
    logic [7:0] w_byte;

    assign w_pins = {i_lcd_rst, i_lcd_cs, i_lcd_dc, i_lcd_mosi, i_lcd_scl};

    // Synchronisers reset to the idle pin levels (RST and CS high) so that
    // leaving block reset does not look like an LCD reset or a chip select.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 5'b11000;
            end
            r_scl_prev <= 1'b0;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_scl_prev <= w_scl_s;
        end
    end

    assign w_scl_s    = r_sync[SYNC_STAGES-1][0];
    assign w_mosi_s   = r_sync[SYNC_STAGES-1][1];
    assign w_dc_s     = r_sync[SYNC_STAGES-1][2];
    assign w_cs_s     = r_sync[SYNC_STAGES-1][3];
    assign w_rst_s    = r_sync[SYNC_STAGES-1][4];
    assign w_scl_rise = w_scl_s & ~r_scl_prev;

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. LCD_RST low wins over CS and SCL in every state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rst_s)     w_state_nxt = S_LCDRST;
                else if (!w_cs_s) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (!w_rst_s)    w_state_nxt = S_LCDRST;
                else if (w_cs_s) w_state_nxt = S_IDLE;
            end
            S_LCDRST: begin
                if (w_rst_s)     w_state_nxt = S_IDLE;
            end
            default:             w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        w_shift_en  = 1'b0;
        w_clr_bits  = 1'b0;
        w_abort_evt = 1'b0;
        w_rst_run   = 1'b0;
        w_rst_rel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr_bits = 1'b1;
                w_rst_run  = ~w_rst_s;
            end
            S_SHIFT: begin
                if (!w_rst_s) begin
                    w_rst_run = 1'b1;
                end else if (w_cs_s) begin
                    w_clr_bits  = 1'b1;
                    w_abort_evt = (r_bit_cnt != 3'd0);
                end else if (w_scl_rise) begin
                    w_shift_en = 1'b1;
                end
            end
            S_LCDRST: begin
                w_clr_bits = 1'b1;
                w_rst_run  = ~w_rst_s;
                w_rst_rel  = w_rst_s;
            end
            default: w_clr_bits = 1'b1;
        endcase
    end

    assign w_byte      = {r_shift[6:0], w_mosi_s};
    assign w_byte_done = w_shift_en && (r_bit_cnt == 3'd7);
    // A handshake in the same cycle frees the register for the new byte.
    assign w_load      = w_byte_done && (!r_valid || i_byte_ready);
    assign w_ovr_evt   = w_byte_done && r_valid && !i_byte_ready;
    assign w_hw_ok     = w_rst_rel && (r_rst_cnt >= RST_CNT_W'(RST_MIN_CYC));
    assign w_glitch    = w_rst_rel && (r_rst_cnt <  RST_CNT_W'(RST_MIN_CYC));

    // Shift register and bit counter; the 3-bit count wraps to 0 on the 8th bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (w_clr_bits) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (w_shift_en) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Reset-low counter: counts every synced-low cycle including the one
    // that moves the FSM into LCDRST, so the count equals the low width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_cnt <= '0;
        end else if (w_rst_rel) begin
            r_rst_cnt <= '0;
        end else if (w_rst_run && (r_rst_cnt != '1)) begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
        end
    end

    // Output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= 8'h00;
            r_dc    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_byte;
                r_dc   <= w_dc_s;
            end
            if (r_state == S_LCDRST)         r_valid <= 1'b0;
            else if (w_load)                 r_valid <= 1'b1;
            else if (r_valid && i_byte_ready) r_valid <= 1'b0;
        end
    end

    // Event pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun    <= 1'b0;
            r_abort      <= 1'b0;
            r_hwrst_done <= 1'b0;
            r_rst_glitch <= 1'b0;
        end else begin
            r_overrun    <= w_ovr_evt;
            r_abort      <= w_abort_evt;
            r_hwrst_done <= w_hw_ok;
            r_rst_glitch <= w_glitch;
        end
    end

    assign o_byte_data  = r_data;
    assign o_byte_dc    = r_dc;
    assign o_byte_valid = r_valid;
    assign o_overrun    = r_overrun;
    assign o_abort      = r_abort;
    assign o_hwrst_done = r_hwrst_done;
    assign o_rst_glitch = r_rst_glitch;

`ifdef LCD_SPI_RX_CMD_DECODE_EN
    logic [7:0] r_last_cmd;
    logic       r_disp_on, r_sleep_out;

    // Only bytes that actually enter the output register are decoded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_cmd  <= 8'h00;
            r_disp_on   <= 1'b0;
            r_sleep_out <= 1'b0;
        end else if (w_hw_ok) begin
            r_last_cmd  <= 8'h00;
            r_disp_on   <= 1'b0;
            r_sleep_out <= 1'b0;
        end else if (w_load && !w_dc_s) begin
            r_last_cmd <= w_byte;
            case (w_byte)
                8'h29: r_disp_on   <= 1'b1;
                8'h28: r_disp_on   <= 1'b0;
                8'h11: r_sleep_out <= 1'b1;
                8'h10: r_sleep_out <= 1'b0;
                8'h01: begin
                    r_disp_on   <= 1'b0;
                    r_sleep_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_last_cmd  = r_last_cmd;
    assign o_disp_on   = r_disp_on;
    assign o_sleep_out = r_sleep_out;
`else
    assign o_last_cmd  = 8'h00;
    assign o_disp_on   = 1'b0;
    assign o_sleep_out = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Purpose  : directed self-checking bench for lcd_spi_rx with a byte scoreboard.
// Latency  : bytes are compared when the DUT hands them over (valid and ready).
// Backpress: i_byte_ready is driven by the directed steps to provoke overrun.

module tb_lcd_spi_rx;

`ifdef LCD_SPI_RX_CMD_DECODE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_scl, lcd_mosi, lcd_dc, lcd_cs, lcd_rst;
    logic [7:0] byte_data;
    logic       byte_dc, byte_valid, byte_ready;
    logic       overrun, abort_p, hwrst_done, rst_glitch;
    logic [7:0] last_cmd;
    logic       disp_on, sleep_out;

    int total = 0;
    int bad   = 0;
    int n_ab = 0, n_ov = 0, n_hw = 0, n_gl = 0;
    int e_ab = 0, e_ov = 0, e_hw = 0, e_gl = 0;
    logic [8:0] sb_q [$];
    logic [8:0] exp_b;

    always #5 clk = ~clk;

    lcd_spi_rx dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_lcd_scl    (lcd_scl),
        .i_lcd_mosi   (lcd_mosi),
        .i_lcd_dc     (lcd_dc),
        .i_lcd_cs     (lcd_cs),
        .i_lcd_rst    (lcd_rst),
        .o_byte_data  (byte_data),
        .o_byte_dc    (byte_dc),
        .o_byte_valid (byte_valid),
        .i_byte_ready (byte_ready),
        .o_overrun    (overrun),
        .o_abort      (abort_p),
        .o_hwrst_done (hwrst_done),
        .o_rst_glitch (rst_glitch),
        .o_last_cmd   (last_cmd),
        .o_disp_on    (disp_on),
        .o_sleep_out  (sleep_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: count pulses and score bytes at the handshake, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (abort_p)    n_ab++;
            if (overrun)    n_ov++;
            if (hwrst_done) n_hw++;
            if (rst_glitch) n_gl++;
            if (byte_valid && byte_ready) begin
                check("byte_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_b = sb_q.pop_front();
                    check("byte", 32'({byte_dc, byte_data}), 32'(exp_b));
                end
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            lcd_mosi = b[7-i];
            cyc(4);
            lcd_scl = 1'b1;
            cyc(4);
            lcd_scl = 1'b0;
        end
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b, input bit push);
        lcd_dc = dc;
        if (push) sb_q.push_back({dc, b});
        send_bits(b, 8);
        cyc(6);
    endtask

    task automatic lcd_reset(input int n);
        lcd_rst = 1'b0;
        cyc(n);
        lcd_rst = 1'b1;
        cyc(10);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_abort"},   32'(n_ab), 32'(e_ab));
        check({tag, "_overrun"}, 32'(n_ov), 32'(e_ov));
        check({tag, "_hwrst"},   32'(n_hw), 32'(e_hw));
        check({tag, "_glitch"},  32'(n_gl), 32'(e_gl));
    endtask

    initial begin
        rst_n      = 1'b0;
        lcd_scl    = 1'b0;
        lcd_mosi   = 1'b0;
        lcd_dc     = 1'b0;
        lcd_cs     = 1'b1;
        lcd_rst    = 1'b1;
        byte_ready = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        // Reset state
        check("rst_valid",    32'(byte_valid), 32'd0);
        check("rst_data",     32'(byte_data),  32'd0);
        check("rst_dc",       32'(byte_dc),    32'd0);
        check("rst_last_cmd", 32'(last_cmd),   32'd0);
        check("rst_disp_on",  32'(disp_on),    32'd0);
        check("rst_sleep",    32'(sleep_out),  32'd0);
        check_counts("rst");

        // Long LCD reset -> HWRST_DONE
        lcd_reset(200);
        e_hw++;
        check_counts("hwrst200");

        // Short LCD reset -> RST_GLITCH
        lcd_reset(50);
        e_gl++;
        check_counts("glitch50");

        // Command 0x29 with ready=1
        byte_ready = 1'b1;
        lcd_cs = 1'b0;
        cyc(4);
        send_byte(1'b0, 8'h29, 1'b1);
        check("cmd29_sb_empty", 32'(sb_q.size()), 32'd0);
        check("cmd29_valid_drop", 32'(byte_valid), 32'd0);
        check("cmd29_disp_on",  32'(disp_on),  32'(DEC));
        check("cmd29_last_cmd", 32'(last_cmd), DEC ? 32'h29 : 32'h0);

        // Command 0x11
        send_byte(1'b0, 8'h11, 1'b1);
        check("cmd11_sleep", 32'(sleep_out), 32'(DEC));
        check("cmd11_last_cmd", 32'(last_cmd), DEC ? 32'h11 : 32'h0);

        // Data byte does not touch the command status
        send_byte(1'b1, 8'h5A, 1'b1);
        check("data5a_last_cmd", 32'(last_cmd), DEC ? 32'h11 : 32'h0);
        check("data5a_sb_empty", 32'(sb_q.size()), 32'd0);

        // Overrun: 0xA5 held, 0x3C dropped
        byte_ready = 1'b0;
        send_byte(1'b1, 8'hA5, 1'b1);
        check("ovr_valid", 32'(byte_valid), 32'd1);
        check("ovr_data1", 32'(byte_data),  32'hA5);
        check("ovr_dc1",   32'(byte_dc),    32'd1);
        send_byte(1'b0, 8'h3C, 1'b0);
        e_ov++;
        check("ovr_data2", 32'(byte_data), 32'hA5);
        check("ovr_dc2",   32'(byte_dc),   32'd1);
        check("ovr_last_cmd", 32'(last_cmd), DEC ? 32'h11 : 32'h0);
        check_counts("ovr");
        byte_ready = 1'b1;
        cyc(4);
        check("ovr_drain_valid", 32'(byte_valid), 32'd0);
        check("ovr_drain_sb",    32'(sb_q.size()), 32'd0);

        // Abort after 5 bits, then a full byte decodes
        send_bits(8'hF0, 5);
        cyc(2);
        lcd_cs = 1'b1;
        cyc(6);
        e_ab++;
        check_counts("abort");
        check("abort_valid", 32'(byte_valid), 32'd0);
        lcd_cs = 1'b0;
        cyc(4);
        send_byte(1'b0, 8'h28, 1'b1);
        check("cmd28_disp_on",  32'(disp_on),  32'd0);
        check("cmd28_sleep",    32'(sleep_out), 32'(DEC));
        check("cmd28_last_cmd", 32'(last_cmd), DEC ? 32'h28 : 32'h0);
        check("cmd28_sb_empty", 32'(sb_q.size()), 32'd0);

        // LCD reset mid-byte with a held byte: flushed, no emission
        byte_ready = 1'b0;
        send_byte(1'b1, 8'h77, 1'b0);
        check("mid_valid_before", 32'(byte_valid), 32'd1);
        send_bits(8'hE0, 3);
        cyc(2);
        lcd_reset(150);
        e_hw++;
        check("mid_valid_after", 32'(byte_valid), 32'd0);
        check("mid_last_cmd",    32'(last_cmd),   32'd0);
        check("mid_sleep",       32'(sleep_out),  32'd0);
        check_counts("midrst");
        byte_ready = 1'b1;
        cyc(5);
        check("mid_no_emit", 32'(byte_valid), 32'd0);

        // Byte after LCD reset starts from a clean bit count
        send_byte(1'b1, 8'hC3, 1'b1);
        cyc(4);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        check_counts("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
